// File: rtl/xadac_axi_rd_arb_if.sv
// ---------------------------------------------------------------------------
// xadac_axi_rd_arb_if
//   Single-beat AXI read channel bundle (AR + R). Each handshake signal has
//   Lanes copies, and each id/addr/data field is packed Lanes times. The
//   requester side of the arbiter uses Lanes = number of requesters; the
//   memory side uses Lanes = 1.
//
//   Signals (per lane):
//     ar_id / ar_addr / ar_valid   read request from the issuing side
//     ar_ready                     request accepted
//     r_id / r_data / r_valid      read response to the issuing side
//     r_ready                      response accepted
//
//   Modports:
//     master  issues AR and consumes R
//     slave   accepts AR and produces R
// ---------------------------------------------------------------------------
interface xadac_axi_rd_arb_if #(
    parameter int unsigned Lanes     = 1,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 128
);
    logic [Lanes*IdWidth-1:0]   ar_id;
    logic [Lanes*AddrWidth-1:0] ar_addr;
    logic [Lanes-1:0]           ar_valid;
    logic [Lanes-1:0]           ar_ready;
    logic [Lanes*IdWidth-1:0]   r_id;
    logic [Lanes*DataWidth-1:0] r_data;
    logic [Lanes-1:0]           r_valid;
    logic [Lanes-1:0]           r_ready;

    modport master (
        output ar_id, ar_addr, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_valid,
        output r_ready
    );

    modport slave (
        input  ar_id, ar_addr, ar_valid,
        output ar_ready,
        output r_id, r_data, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/xadac_axi_rd_arb.sv
// ---------------------------------------------------------------------------
// xadac_axi_rd_arb
//   Shares the single xadac AXI read channel among NoReq read requesters.
//   AR: round-robin arbitration into one registered output slot; the winner's
//   index is prepended above its id. R: beats are routed back by that index
//   field, data is broadcast. Each requester may have at most MaxOutstanding
//   reads in flight. Single-beat reads only.
//
//   Ports:
//     clk         clock, rising edge
//     rstn        asynchronous reset, active low
//     req         requester side (slave modport, NoReq lanes, IdWidth ids)
//     m           AXI side (master modport, 1 lane, IdWidth+IdxW ids)
//     idle        no read in flight and AR slot empty
//     err_bad_id  sticky: an R beat arrived with an index >= NoReq
// ---------------------------------------------------------------------------
module xadac_axi_rd_arb #(
    parameter int unsigned NoReq          = 2,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 128,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                clk,
    input  logic                rstn,
    xadac_axi_rd_arb_if.slave   req,
    xadac_axi_rd_arb_if.master  m,
    output logic                idle,
    output logic                err_bad_id
);

    localparam int unsigned IdxW = (NoReq > 1) ? $clog2(NoReq) : 1;
    localparam int unsigned MIdW = IdWidth + IdxW;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef logic [CntW-1:0] cnt_t;

    // Registered state
    logic                 ar_valid_q;
    logic [MIdW-1:0]      ar_id_q;
    logic [AddrWidth-1:0] ar_addr_q;
    logic [IdxW-1:0]      rr_ptr_q;
    cnt_t                 cnt_q [NoReq];
    logic                 err_q;

    // Arbitration
    logic                 slot_free;
    logic [NoReq-1:0]     eligible;
    logic                 gnt_vld;
    logic [IdxW-1:0]      gnt_idx;
    logic [IdxW-1:0]      rr_ptr_nxt;
    logic [IdWidth-1:0]   gnt_id;
    logic [AddrWidth-1:0] gnt_addr;

    // Response routing
    logic [IdxW-1:0]      r_idx;
    logic                 r_idx_ok;
    logic                 r_sel_ready;

    logic [NoReq-1:0]     ar_hs;
    logic [NoReq-1:0]     r_hs;

    assign slot_free = !ar_valid_q || m.ar_ready[0];

    // Eligibility looks at the registered count only, so a requester at its
    // limit stays blocked in the cycle its retiring beat is accepted.
    always_comb begin
        for (int i = 0; i < NoReq; i++) begin
            eligible[i] = req.ar_valid[i] && (cnt_q[i] < cnt_t'(MaxOutstanding));
        end
    end

    // First eligible requester scanning upward from the pointer, with wrap.
    always_comb begin
        int unsigned cand;
        // NOTE: every combinational output gets a default before any
        // conditional assignment; a path that leaves one unassigned infers a latch.
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        for (int unsigned k = 0; k < NoReq; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NoReq) begin
                cand = cand - NoReq;
            end
            if (!gnt_vld && eligible[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = IdxW'(cand);
            end
        end
    end

    always_comb begin
        gnt_id   = '0;
        gnt_addr = '0;
        for (int i = 0; i < NoReq; i++) begin
            if (gnt_idx == IdxW'(i)) begin
                gnt_id   = req.ar_id[i*IdWidth +: IdWidth];
                gnt_addr = req.ar_addr[i*AddrWidth +: AddrWidth];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NoReq; i++) begin
            req.ar_ready[i] = slot_free && gnt_vld && (gnt_idx == IdxW'(i));
        end
    end

    assign rr_ptr_nxt = (32'(gnt_idx) == NoReq - 1) ? '0 : gnt_idx + IdxW'(1);

    // R path: purely combinational, steered by the index field of the id.
    assign r_idx = m.r_id[MIdW-1:IdWidth];

    always_comb begin
        req.r_valid = '0;
        r_idx_ok    = 1'b0;
        r_sel_ready = 1'b0;
        for (int i = 0; i < NoReq; i++) begin
            if (r_idx == IdxW'(i)) begin
                req.r_valid[i] = m.r_valid[0];
                r_idx_ok       = 1'b1;
                r_sel_ready    = req.r_ready[i];
            end
        end
    end

    // Beats with an out-of-range index are accepted and discarded so the
    // channel cannot lock up.
    assign m.r_ready[0] = r_idx_ok ? r_sel_ready : 1'b1;

    for (genvar g = 0; g < NoReq; g++) begin : g_r_bcast
        assign req.r_id[g*IdWidth +: IdWidth]       = m.r_id[IdWidth-1:0];
        assign req.r_data[g*DataWidth +: DataWidth] = m.r_data;
    end

    assign ar_hs = req.ar_valid & req.ar_ready;
    assign r_hs  = req.r_valid & req.r_ready;

    // Output slot and round-robin pointer. While the slot is occupied and
    // not yet accepted, its contents are frozen.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_valid_q <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            rr_ptr_q   <= '0;
        end else if (slot_free) begin
            if (gnt_vld) begin
                ar_valid_q <= 1'b1;
                ar_id_q    <= {gnt_idx, gnt_id};
                ar_addr_q  <= gnt_addr;
                rr_ptr_q   <= rr_ptr_nxt;
            end else begin
                ar_valid_q <= 1'b0;
            end
        end
    end

    // Outstanding counters: +1 on requester AR handshake, -1 on retired R
    // beat, unchanged when both happen together, never below zero (beats
    // that were in flight across a reset are absorbed).
    // NOTE: the counter array is control state, not storage, so every entry
    // is reset; a plain data memory would not be.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NoReq; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NoReq; i++) begin
                if (ar_hs[i] && !r_hs[i]) begin
                    cnt_q[i] <= cnt_q[i] + cnt_t'(1);
                end else if (!ar_hs[i] && r_hs[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (m.r_valid[0] && !r_idx_ok) begin
            err_q <= 1'b1;
        end
    end

    always_comb begin
        idle = !ar_valid_q;
        for (int i = 0; i < NoReq; i++) begin
            if (cnt_q[i] != '0) begin
                idle = 1'b0;
            end
        end
    end

    assign m.ar_valid[0] = ar_valid_q;
    assign m.ar_id       = ar_id_q;
    assign m.ar_addr     = ar_addr_q;
    assign err_bad_id    = err_q;

endmodule
